fp32_mul_pipe: RTL and testbench

FP32_MUL_PIPE -- requirements
Module: fp32_mul_pipe

---
 rtl/fp32_mul_pipe_if.sv | 21 ++
 rtl/fp32_mul_pipe.sv | 204 ++++++++++++++++++++
 tb/tb_fp32_mul_pipe.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp32_mul_pipe_if.sv
// rtl/fp32_mul_pipe_if.sv - operand/result bundle for the pipelined binary32 multiplier
interface fp32_mul_pipe_if;
    logic        I_Valid;
    logic [31:0] I_A;
    logic [31:0] I_B;
    logic        I_Stall;
    logic        I_Flush;
    logic        O_Valid;
    logic [31:0] O_Result;
    logic [3:0]  O_Flags;

    modport master (
        output I_Valid, I_A, I_B, I_Stall, I_Flush,
        input  O_Valid, O_Result, O_Flags
    );

    modport slave (
        input  I_Valid, I_A, I_B, I_Stall, I_Flush,
        output O_Valid, O_Result, O_Flags
    );
endinterface

// File: rtl/fp32_mul_pipe.sv
// rtl/fp32_mul_pipe.sv - 3-stage binary32 multiplier, RNE, DAZ/FTZ, stall/flush, optional output stages
module fp32_mul_pipe #(
    parameter int EXTRA_OUT_STAGES = 0
) (
    input  logic          I_Clk,
    input  logic          I_nReset,
    fp32_mul_pipe_if.slave bus
);
    // Stage 1: unpack and classify
    logic [7:0]  a_exp, b_exp;
    logic [22:0] a_frac, b_frac;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
    logic        s1_valid_q, s2_valid_q, s3_valid_q;
    logic        s1_sign_q, s1_sign_d;
    logic signed [9:0] s1_exp_q, s1_exp_d;
    logic [23:0] s1_ma_q, s1_ma_d, s1_mb_q, s1_mb_d;
    logic        s1_spec_q, s1_spec_d;
    logic [31:0] s1_spec_res_q, s1_spec_res_d;
    logic [3:0]  s1_spec_flg_q, s1_spec_flg_d;

    // Stage 2: significand product
    logic        s2_sign_q;
    logic signed [9:0] s2_exp_q;
    logic [47:0] s2_prod_q, s2_prod_d;
    logic        s2_spec_q;
    logic [31:0] s2_spec_res_q;
    logic [3:0]  s2_spec_flg_q;

    // Stage 3: normalize, round, pack
    logic [31:0] s3_res_q, s3_res_d;
    logic [3:0]  s3_flg_q, s3_flg_d;
    logic [23:0] mant;
    logic [24:0] mant_r;
    logic        guard, sticky, round_up;
    logic signed [9:0] exp_n, exp_r;

    assign a_exp  = bus.I_A[30:23];
    assign b_exp  = bus.I_B[30:23];
    assign a_frac = bus.I_A[22:0];
    assign b_frac = bus.I_B[22:0];

    // Classify operands (denormals count as zero) and resolve special results early
    always_comb begin
        a_zero = (a_exp == 8'd0);
        b_zero = (b_exp == 8'd0);
        a_inf  = (a_exp == 8'hFF) && (a_frac == 23'd0);
        b_inf  = (b_exp == 8'hFF) && (b_frac == 23'd0);
        a_nan  = (a_exp == 8'hFF) && (a_frac != 23'd0);
        b_nan  = (b_exp == 8'hFF) && (b_frac != 23'd0);
        a_snan = a_nan && !a_frac[22];
        b_snan = b_nan && !b_frac[22];
        s1_sign_d     = bus.I_A[31] ^ bus.I_B[31];
        s1_exp_d      = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - 10'sd127;
        s1_ma_d       = {1'b1, a_frac};
        s1_mb_d       = {1'b1, b_frac};
        s1_spec_d     = 1'b0;
        s1_spec_res_d = 32'd0;
        s1_spec_flg_d = 4'd0;
        if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) begin
            s1_spec_d     = 1'b1;
            s1_spec_res_d = 32'h7FC0_0000;
            s1_spec_flg_d = {(a_snan || b_snan || (a_zero && b_inf) || (a_inf && b_zero)), 3'b000};
        end else if (a_inf || b_inf) begin
            s1_spec_d     = 1'b1;
            s1_spec_res_d = {s1_sign_d, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
            s1_spec_d     = 1'b1;
            s1_spec_res_d = {s1_sign_d, 31'd0};
        end
    end

    // Full-width significand product
    always_comb begin
        s2_prod_d = {24'd0, s1_ma_q} * {24'd0, s1_mb_q};
    end

    // Normalize by at most one place, round to nearest even, then saturate to inf or flush to zero
    always_comb begin
        if (s2_prod_q[47]) begin
            mant   = s2_prod_q[47:24];
            guard  = s2_prod_q[23];
            sticky = |s2_prod_q[22:0];
            exp_n  = s2_exp_q + 10'sd1;
        end else begin
            mant   = s2_prod_q[46:23];
            guard  = s2_prod_q[22];
            sticky = |s2_prod_q[21:0];
            exp_n  = s2_exp_q;
        end
        round_up = guard && (sticky || mant[0]);
        mant_r   = {1'b0, mant} + {24'd0, round_up};
        exp_r    = exp_n + $signed({9'd0, mant_r[24]});
        if (s2_spec_q) begin
            s3_res_d = s2_spec_res_q;
            s3_flg_d = s2_spec_flg_q;
        end else if (exp_n <= 10'sd0) begin
            s3_res_d = {s2_sign_q, 31'd0};
            s3_flg_d = 4'b0011;
        end else if (exp_r >= 10'sd255) begin
            s3_res_d = {s2_sign_q, 8'hFF, 23'd0};
            s3_flg_d = 4'b0101;
        end else begin
            s3_res_d = {s2_sign_q, exp_r[7:0], (mant_r[24] ? mant_r[23:1] : mant_r[22:0])};
            s3_flg_d = {3'b000, (guard || sticky)};
        end
    end

    // Valid bits: flush clears (and beats stall), stall holds, otherwise advance
    always_ff @(posedge I_Clk or negedge I_nReset) begin
        if (!I_nReset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
        end else if (bus.I_Flush) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
        end else if (!bus.I_Stall) begin
            s1_valid_q <= bus.I_Valid;
            s2_valid_q <= s1_valid_q;
            s3_valid_q <= s2_valid_q;
        end
    end

    // Data registers of all three stages advance together whenever not stalled
    always_ff @(posedge I_Clk or negedge I_nReset) begin
        if (!I_nReset) begin
            s1_sign_q     <= 1'b0;
            s1_exp_q      <= '0;
            s1_ma_q       <= '0;
            s1_mb_q       <= '0;
            s1_spec_q     <= 1'b0;
            s1_spec_res_q <= '0;
            s1_spec_flg_q <= '0;
            s2_sign_q     <= 1'b0;
            s2_exp_q      <= '0;
            s2_prod_q     <= '0;
            s2_spec_q     <= 1'b0;
            s2_spec_res_q <= '0;
            s2_spec_flg_q <= '0;
            s3_res_q      <= '0;
            s3_flg_q      <= '0;
        end else if (!bus.I_Stall) begin
            s1_sign_q     <= s1_sign_d;
            s1_exp_q      <= s1_exp_d;
            s1_ma_q       <= s1_ma_d;
            s1_mb_q       <= s1_mb_d;
            s1_spec_q     <= s1_spec_d;
            s1_spec_res_q <= s1_spec_res_d;
            s1_spec_flg_q <= s1_spec_flg_d;
            s2_sign_q     <= s1_sign_q;
            s2_exp_q      <= s1_exp_q;
            s2_prod_q     <= s2_prod_d;
            s2_spec_q     <= s1_spec_q;
            s2_spec_res_q <= s1_spec_res_q;
            s2_spec_flg_q <= s1_spec_flg_q;
            s3_res_q      <= s3_res_d;
            s3_flg_q      <= s3_flg_d;
        end
    end

    generate
        if (EXTRA_OUT_STAGES > 0) begin : g_extra
            localparam int N = EXTRA_OUT_STAGES;
            logic [N-1:0]       x_valid_q;
            logic [N-1:0][31:0] x_res_q;
            logic [N-1:0][3:0]  x_flg_q;
            logic [N:0]         chain_valid;
            logic [N:0][31:0]   chain_res;
            logic [N:0][3:0]    chain_flg;

            assign chain_valid = {x_valid_q, s3_valid_q};
            assign chain_res   = {x_res_q, s3_res_q};
            assign chain_flg   = {x_flg_q, s3_flg_q};

            // Plain delay stages behind stage 3, same stall/flush rules
            always_ff @(posedge I_Clk or negedge I_nReset) begin
                if (!I_nReset) begin
                    x_valid_q <= '0;
                    x_res_q   <= '0;
                    x_flg_q   <= '0;
                end else begin
                    if (bus.I_Flush) begin
                        x_valid_q <= '0;
                    end else if (!bus.I_Stall) begin
                        x_valid_q <= chain_valid[N-1:0];
                    end
                    if (!bus.I_Stall) begin
                        x_res_q <= chain_res[N-1:0];
                        x_flg_q <= chain_flg[N-1:0];
                    end
                end
            end

            assign bus.O_Valid  = chain_valid[N];
            assign bus.O_Result = chain_res[N];
            assign bus.O_Flags  = chain_flg[N];
        end else begin : g_direct
            assign bus.O_Valid  = s3_valid_q;
            assign bus.O_Result = s3_res_q;
            assign bus.O_Flags  = s3_flg_q;
        end
    endgenerate
endmodule

// File: tb/tb_fp32_mul_pipe.sv
// tb/tb_fp32_mul_pipe.sv - randomized and directed bench for fp32_mul_pipe
module tb_fp32_mul_pipe;
    logic I_Clk;
    logic I_nReset;
    int   n_tests = 0;
    int   n_fail  = 0;

    initial I_Clk = 1'b0;
    always #5 I_Clk = ~I_Clk;

    fp32_mul_pipe_if bus0();
    fp32_mul_pipe_if bus1();

    fp32_mul_pipe #(.EXTRA_OUT_STAGES(0)) dut0 (.I_Clk(I_Clk), .I_nReset(I_nReset), .bus(bus0));
    fp32_mul_pipe #(.EXTRA_OUT_STAGES(2)) dut2 (.I_Clk(I_Clk), .I_nReset(I_nReset), .bus(bus1));

    // Timing model: each accepted op needs two more non-stalled edges before it is visible
    int          q_rem[$];
    logic [31:0] q_res[$];
    logic [3:0]  q_flg[$];
    logic        exp_valid;
    logic [31:0] exp_res;
    logic [3:0]  exp_flg;
    logic        last_stall;

    function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic [3:0] f);
        int ea, eb, e, e_pre, sh;
        longint unsigned ma, mb, p, m, rem, half;
        logic s, up, az, bz, ai, bi, an, bn, asn, bsn;
        ea = int'(a[30:23]); eb = int'(b[30:23]);
        az = (ea == 0); bz = (eb == 0);
        ai = (ea == 255) && (a[22:0] == 0); bi = (eb == 255) && (b[22:0] == 0);
        an = (ea == 255) && (a[22:0] != 0); bn = (eb == 255) && (b[22:0] != 0);
        asn = an && !a[22]; bsn = bn && !b[22];
        s = a[31] ^ b[31];
        f = 4'd0;
        if (an || bn || (az && bi) || (ai && bz)) begin
            r = 32'h7FC0_0000;
            f[3] = asn || bsn || (az && bi) || (ai && bz);
            return;
        end
        if (ai || bi) begin r = {s, 8'hFF, 23'd0}; return; end
        if (az || bz) begin r = {s, 31'd0}; return; end
        ma = {40'd0, 1'b1, a[22:0]};
        mb = {40'd0, 1'b1, b[22:0]};
        p  = ma * mb;
        e  = ea + eb - 127;
        if (p >= (64'd1 << 47)) begin sh = 24; e = e + 1; end
        else sh = 23;
        m    = p >> sh;
        rem  = p - (m << sh);
        half = 64'd1 << (sh - 1);
        up   = (rem > half) || ((rem == half) && m[0]);
        e_pre = e;
        m = m + {63'd0, up};
        if (m == (64'd1 << 24)) begin m = m >> 1; e = e + 1; end
        if (e_pre <= 0) begin r = {s, 31'd0}; f = 4'b0011; end
        else if (e >= 255) begin r = {s, 8'hFF, 23'd0}; f = 4'b0101; end
        else begin r = {s, e[7:0], m[22:0]}; f = {3'b000, (rem != 0)}; end
    endfunction

    function automatic logic [31:0] rand_op();
        int k;
        logic [31:0] v;
        k = $urandom_range(0, 19);
        v = $urandom;
        case (k)
            0: rand_op = {v[31], 31'd0};
            1: rand_op = {v[31], 8'hFF, 23'd0};
            2: rand_op = {v[31], 8'hFF, 1'b1, v[21:0]};
            3: rand_op = {v[31], 8'hFF, 1'b0, v[21:1], 1'b1};
            4: rand_op = {v[31], 8'h00, v[22:1], 1'b1};
            5: rand_op = {v[31], 8'(250 + $urandom_range(0, 4)), v[22:0]};
            6: rand_op = {v[31], 8'(1 + $urandom_range(0, 4)), v[22:0]};
            default: rand_op = {v[31], 8'(100 + $urandom_range(0, 54)), v[22:0]};
        endcase
    endfunction

    task automatic model_clear();
        q_rem.delete(); q_res.delete(); q_flg.delete();
        exp_valid = 1'b0;
    endtask

    task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic st, input logic fl);
        logic [31:0] r;
        logic [3:0]  f;
        bus0.I_Valid = v; bus0.I_A = a; bus0.I_B = b;
        bus0.I_Stall = st; bus0.I_Flush = fl;
        @(posedge I_Clk);
        if (fl) begin
            model_clear();
        end else if (!st) begin
            for (int i = 0; i < q_rem.size(); i++) q_rem[i] = q_rem[i] - 1;
            if (q_rem.size() > 0 && q_rem[0] == 0) begin
                exp_valid = 1'b1;
                exp_res   = q_res.pop_front();
                exp_flg   = q_flg.pop_front();
                void'(q_rem.pop_front());
            end else begin
                exp_valid = 1'b0;
            end
            if (v) begin
                ref_mul(a, b, r, f);
                q_rem.push_back(2); q_res.push_back(r); q_flg.push_back(f);
            end
        end
        last_stall = st && !fl;
        @(negedge I_Clk);
    endtask

    task automatic test_reset();
        I_nReset = 1'b0;
        bus0.I_Valid = 1'b0; bus0.I_A = '0; bus0.I_B = '0; bus0.I_Stall = 1'b0; bus0.I_Flush = 1'b0;
        bus1.I_Valid = 1'b0; bus1.I_A = '0; bus1.I_B = '0; bus1.I_Stall = 1'b0; bus1.I_Flush = 1'b0;
        model_clear();
        last_stall = 1'b0;
        repeat (3) @(negedge I_Clk);
        n_tests++; if (bus0.O_Valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus0.O_Valid); end
        n_tests++; if (bus0.O_Result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h expected 00000000", bus0.O_Result); end
        n_tests++; if (bus0.O_Flags !== 4'd0) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", bus0.O_Flags); end
        n_tests++; if (bus1.O_Valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid_x2: got %b expected 0", bus1.O_Valid); end
        I_nReset = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] ta [5] = '{32'h3FC00000, 32'h3F800001, 32'h7F7FFFFF, 32'h7F800000, 32'h00800000};
        logic [31:0] tb [5] = '{32'h40000000, 32'h3F800001, 32'h40000000, 32'h00000000, 32'h3F000000};
        logic [31:0] tr [5] = '{32'h40400000, 32'h3F800002, 32'h7F800000, 32'h7FC00000, 32'h00000000};
        logic [3:0]  tf [5] = '{4'b0000, 4'b0001, 4'b0101, 4'b1000, 4'b0011};
        for (int c = 0; c < 8; c++) begin
            if (c < 5) cycle(1'b1, ta[c], tb[c], 1'b0, 1'b0);
            else       cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
            if (c >= 2 && c < 7) begin
                n_tests++;
                if (bus0.O_Valid !== 1'b1 || bus0.O_Result !== tr[c-2] || bus0.O_Flags !== tf[c-2]) begin
                    n_fail++;
                    $display("FAIL directed_%0d: got v=%b %h/%b expected v=1 %h/%b", c - 2,
                             bus0.O_Valid, bus0.O_Result, bus0.O_Flags, tr[c-2], tf[c-2]);
                end
            end else begin
                n_tests++;
                if (bus0.O_Valid !== 1'b0) begin n_fail++; $display("FAIL directed_idle_c%0d: got v=%b expected 0", c, bus0.O_Valid); end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 63; c++) begin
            if (c < 60) cycle(($urandom_range(0, 3) != 0), rand_op(), rand_op(), 1'b0, 1'b0);
            else        cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
            n_tests++;
            if (bus0.O_Valid !== exp_valid) begin n_fail++; $display("FAIL random_valid c%0d: got %b expected %b", c, bus0.O_Valid, exp_valid); end
            if (exp_valid) begin
                n_tests++;
                if (bus0.O_Result !== exp_res || bus0.O_Flags !== exp_flg) begin
                    n_fail++;
                    $display("FAIL random_data c%0d: got %h/%b expected %h/%b", c, bus0.O_Result, bus0.O_Flags, exp_res, exp_flg);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int issued = 0, nout = 0, c = 0;
        int in_cyc [8];
        int out_cyc [8];
        logic st;
        while ((issued < 8 || nout < 8) && c < 40) begin
            st = (c == 4 || c == 5);
            if (!st && issued < 8) begin
                in_cyc[issued] = c; issued++;
                cycle(1'b1, rand_op(), rand_op(), 1'b0, 1'b0);
            end else begin
                cycle(st, rand_op(), rand_op(), st, 1'b0);
            end
            n_tests++;
            if (bus0.O_Valid !== exp_valid) begin n_fail++; $display("FAIL b2b_valid c%0d: got %b expected %b", c, bus0.O_Valid, exp_valid); end
            if (exp_valid) begin
                n_tests++;
                if (bus0.O_Result !== exp_res || bus0.O_Flags !== exp_flg) begin
                    n_fail++;
                    $display("FAIL b2b_data c%0d: got %h/%b expected %h/%b", c, bus0.O_Result, bus0.O_Flags, exp_res, exp_flg);
                end
            end
            if (bus0.O_Valid && !last_stall) begin
                if (nout < 8) out_cyc[nout] = c;
                nout++;
            end
            c++;
        end
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
            if (bus0.O_Valid) nout++;
        end
        n_tests++;
        if (nout !== 8) begin n_fail++; $display("FAIL b2b_count: got %0d results expected 8", nout); end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (out_cyc[i] - in_cyc[i] !== ((i == 2 || i == 3) ? 4 : 2)) begin
                n_fail++;
                $display("FAIL b2b_latency op%0d: got %0d expected %0d", i, out_cyc[i] - in_cyc[i], (i == 2 || i == 3) ? 4 : 2);
            end
        end
    endtask

    task automatic test_flush();
        logic [31:0] da, db, dr;
        logic [3:0]  df;
        da = 32'h40490FDB; db = 32'hC0000000;
        ref_mul(da, db, dr, df);
        for (int c = 0; c < 8; c++) begin
            case (c)
                0, 1: cycle(1'b1, rand_op(), rand_op(), 1'b0, 1'b0);
                2:    cycle(1'b1, rand_op(), rand_op(), 1'b1, 1'b1);
                3:    cycle(1'b1, da, db, 1'b0, 1'b0);
                default: cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
            endcase
            n_tests++;
            if (bus0.O_Valid !== (c == 5)) begin n_fail++; $display("FAIL flush_valid c%0d: got %b expected %b", c, bus0.O_Valid, (c == 5)); end
            if (c == 5) begin
                n_tests++;
                if (bus0.O_Result !== dr || bus0.O_Flags !== df) begin
                    n_fail++;
                    $display("FAIL flush_after_data: got %h/%b expected %h/%b", bus0.O_Result, bus0.O_Flags, dr, df);
                end
            end
        end
    endtask

    task automatic test_reset_inflight();
        for (int c = 0; c < 3; c++) cycle(1'b1, rand_op(), rand_op(), 1'b0, 1'b0);
        n_tests++;
        if (bus0.O_Valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid: got %b expected 1", bus0.O_Valid); end
        #2 I_nReset = 1'b0;
        #1;
        n_tests++;
        if (bus0.O_Valid !== 1'b0 || bus0.O_Result !== 32'd0 || bus0.O_Flags !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_async: got v=%b %h/%b expected v=0 00000000/0000", bus0.O_Valid, bus0.O_Result, bus0.O_Flags);
        end
        @(posedge I_Clk);
        @(negedge I_Clk);
        I_nReset = 1'b1;
        model_clear();
        for (int c = 0; c < 8; c++) begin
            if (c == 5) cycle(1'b1, 32'h3FC00000, 32'h40000000, 1'b0, 1'b0);
            else        cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
            n_tests++;
            if (bus0.O_Valid !== (c == 7)) begin n_fail++; $display("FAIL rst_post_valid c%0d: got %b expected %b", c, bus0.O_Valid, (c == 7)); end
            if (c == 7) begin
                n_tests++;
                if (bus0.O_Result !== 32'h40400000 || bus0.O_Flags !== 4'd0) begin
                    n_fail++;
                    $display("FAIL rst_post_data: got %h/%b expected 40400000/0000", bus0.O_Result, bus0.O_Flags);
                end
            end
        end
    endtask

    task automatic test_extra_latency();
        int edges;
        bus1.I_Valid = 1'b1; bus1.I_A = 32'h3FC00000; bus1.I_B = 32'h40000000;
        @(posedge I_Clk);
        edges = 1;
        @(negedge I_Clk);
        bus1.I_Valid = 1'b0;
        while (!bus1.O_Valid && edges < 12) begin
            @(posedge I_Clk);
            edges++;
            @(negedge I_Clk);
        end
        n_tests++;
        if (edges !== 5) begin n_fail++; $display("FAIL extra_latency: got %0d expected 5", edges); end
        n_tests++;
        if (bus1.O_Result !== 32'h40400000 || bus1.O_Flags !== 4'd0) begin
            n_fail++;
            $display("FAIL extra_data: got %h/%b expected 40400000/0000", bus1.O_Result, bus1.O_Flags);
        end
        @(posedge I_Clk);
        @(negedge I_Clk);
        n_tests++;
        if (bus1.O_Valid !== 1'b0) begin n_fail++; $display("FAIL extra_single: got %b expected 0", bus1.O_Valid); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_reset_inflight();
        test_extra_latency();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
